instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch and issue unit for the 4-bit-opcode accumulator processor. Holds the program counter, fetches one instruction word at a time from instruction memory over a request/acknowledge handshake, and presents the opcode field to the control decoder with a valid/ready handshake. It consumes the control decoder's PC-write decision and branch/jump target to select the next fetch address, closing the loop between fetch and control.

## Interface
- ADDR_W, 16, instruction-memory word-address width; PC width.
- INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1:INSTR_W-4].
- RESET_PC, 0, first fetch address after reset.

- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch word address; stable while imem_req=1.
- imem_ack  in  1  memory has returned imem_rdata this cycle.
- imem_rdata  in  INSTR_W  fetched word; sampled only when imem_req=1 and imem_ack=1.
- op  out  4  opcode of the issued instruction, to the control decoder.
- instr  out  INSTR_W  full issued instruction word (immediate/register fields).
- pc  out  ADDR_W  address of the issued instruction.
- instr_valid  out  1  op/instr/pc hold a valid instruction.
- instr_ready  in  1  downstream consumes the instruction this cycle.
- pc_write  in  1  PCWRITE from control; take pc_target as next PC.
- pc_target  in  ADDR_W  redirect address.

## Operation
- States: IDLE, FETCH, HOLD.
- IDLE: entered on reset; unconditionally goes to FETCH on the next edge.
- FETCH: imem_req=1, imem_addr=next-PC register. On imem_ack: capture imem_rdata into instr, imem_addr into pc; go to HOLD. Without ack: stay, address unchanged.
- HOLD: imem_req=0, instr_valid=1; op/instr/pc frozen. On instr_valid & instr_ready (issue): next-PC <= pc_write ? pc_target : pc+1; go to FETCH.
- pc+1 computed modulo 2^ADDR_W: pc = all-ones wraps to 0.
- pc_write/pc_target sampled only on the issue cycle; ignored in any other cycle or state.
- imem_ack while imem_req=0 is ignored; imem_rdata is never captured outside FETCH.
- No speculative prefetch: at most one outstanding request.

## Timing
- Reset values (asynchronous, while reset_n=0): state IDLE, imem_req 0, imem_addr RESET_PC, instr 0, op 4'b0000, pc RESET_PC, instr_valid 0.
- First request: imem_req rises on the first clk edge after reset_n deasserts (IDLE->FETCH), addr RESET_PC.
- Fetch latency: ack in cycle N -> instr_valid=1 and imem_req=0 from cycle N+1.
- Issue: handshake in cycle M -> instr_valid=0, imem_req=1 with new address from cycle M+1.
- Best-case throughput with zero-wait memory: one instruction every 2 cycles.
- instr_ready while instr_valid=0 has no effect.
- Reset mid-fetch or mid-hold: all state returns to reset values immediately; a late ack after reset but before the new request is ignored.
- op is a pure slice of registered instr: no combinational path from any input to op, instr, pc, instr_valid, imem_req or imem_addr.

## Test plan
- Reset release, memory acks same cycle with 16'h1234 at addr 0 -> imem_req rises cycle 1, instr_valid cycle 2 with op=4'h1, pc=0, instr=16'h1234.
- Sequential stream, ready held 1, zero-wait memory, words at 0..3 -> addresses 0,1,2,3 issued on alternate cycles, op matches each word's top nibble.
- Wait states: ack delayed 3 cycles -> imem_addr and imem_req stable for 4 cycles, exactly one capture.
- Redirect: issue of jal (op 4'b0110) with pc_write=1, pc_target=16'h0040 -> next imem_addr=16'h0040; pc_write=1 asserted in HOLD with ready=0 -> no redirect.
- Wrap: issue at pc=16'hFFFF with pc_write=0 -> next fetch addr 16'h0000.
- Backpressure and reset: ready=0 for 5 cycles -> op/instr/pc frozen, imem_req=0; reset_n pulsed low during FETCH -> outputs at reset values same cycle, refetch from RESET_PC after release, stray ack ignored.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue unit: owns the PC, fetches one word at a time over a
// req/ack handshake and issues it to the control decoder over valid/ready.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [3:0]         op,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               pc_write,
   input  logic [ADDR_W-1:0]  pc_target
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             state_reg;
   logic               req_reg;
   logic [ADDR_W-1:0]  addr_reg;
   logic [INSTR_W-1:0] instr_reg;
   logic [ADDR_W-1:0]  pc_reg;
   logic               valid_reg;

   logic               fetch_done;
   logic               issue;
   logic [ADDR_W-1:0]  pc_inc;
   logic [ADDR_W-1:0]  next_pc;

   // Handshake qualifiers are gated by state so stray acks/readys are inert.
   assign fetch_done = (state_reg == FETCH) && req_reg && imem_ack;
   assign issue      = (state_reg == HOLD) && valid_reg && instr_ready;
   assign pc_inc     = pc_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign next_pc    = pc_write ? pc_target : pc_inc;

   // imem_addr doubles as the next-PC register; it only moves on issue.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         req_reg   <= 1'b0;
         addr_reg  <= RESET_PC;
         instr_reg <= '0;
         pc_reg    <= RESET_PC;
         valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               state_reg <= FETCH;
               req_reg   <= 1'b1;
            end
            FETCH: begin
               if (fetch_done) begin
                  instr_reg <= imem_rdata;
                  pc_reg    <= addr_reg;
                  req_reg   <= 1'b0;
                  valid_reg <= 1'b1;
                  state_reg <= HOLD;
               end
            end
            HOLD: begin
               if (issue) begin
                  addr_reg  <= next_pc;
                  req_reg   <= 1'b1;
                  valid_reg <= 1'b0;
                  state_reg <= FETCH;
               end
            end
            default: begin
               state_reg <= IDLE;
               req_reg   <= 1'b0;
               valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = req_reg;
   assign imem_addr   = addr_reg;
   assign instr       = instr_reg;
   assign op          = instr_reg[INSTR_W-1 -: 4];
   assign pc          = pc_reg;
   assign instr_valid = valid_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a behavioural memory responder pushes
// each delivered word, and the issued instruction is popped and compared.
module tb_instr_fetch_unit;

   localparam int          AW     = 16;
   localparam int          IW     = 16;
   localparam logic [15:0] RST_PC = 16'h0000;

   logic          clk;
   logic          reset_n;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack;
   logic [IW-1:0] imem_rdata;
   logic [3:0]    op;
   logic [IW-1:0] instr;
   logic [AW-1:0] pc;
   logic          instr_valid;
   logic          instr_ready;
   logic          pc_write;
   logic [AW-1:0] pc_target;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] word;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] exp_addr   = RST_PC;
   logic        keep_ready = 1'b0;
   int          cyc        = 0;
   int          last_issue = 0;
   int          tests_run  = 0;
   int          tests_failed = 0;

   instr_fetch_unit #(
      .ADDR_W   (AW),
      .INSTR_W  (IW),
      .RESET_PC (RST_PC)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .op          (op),
      .instr       (instr),
      .pc          (pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pc_write    (pc_write),
      .pc_target   (pc_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One fetch + issue transaction. Called at a negedge; returns at a negedge
   // one cycle after the issue handshake.
   task automatic fetch_issue(input int waits, input logic [15:0] word, input int hold,
                              input logic stray_pw, input logic pw, input logic [15:0] tgt,
                              input logic spacing);
      exp_t e;
      int   n;
      n = 0;
      while (!imem_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!imem_req) check_val("req_timeout", 32'(imem_req), 32'd1);
      check_val("fetch_addr", 32'(imem_addr), 32'(exp_addr));
      for (int i = 0; i < waits; i++) begin
         imem_ack = 1'b0;
         @(negedge clk);
         check_val("wait_req", 32'(imem_req), 32'd1);
         check_val("wait_addr", 32'(imem_addr), 32'(exp_addr));
         check_val("wait_valid", 32'(instr_valid), 32'd0);
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      sb.push_back('{addr: exp_addr, word: word});
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 16'hDEAD;
      check_val("hold_valid", 32'(instr_valid), 32'd1);
      check_val("hold_req", 32'(imem_req), 32'd0);
      if (sb.size() == 0) begin
         check_val("sb_empty", 32'(sb.size()), 32'd1);
         e = '0;
      end else begin
         e = sb.pop_front();
      end
      check_val("instr", 32'(instr), 32'(e.word));
      check_val("op", 32'(op), 32'(e.word[15:12]));
      check_val("pc", 32'(pc), 32'(e.addr));
      for (int i = 0; i < hold; i++) begin
         instr_ready = 1'b0;
         pc_write    = stray_pw;
         pc_target   = 16'h7777;
         imem_ack    = 1'b1;
         imem_rdata  = 16'hBEEF;
         @(negedge clk);
         check_val("bp_valid", 32'(instr_valid), 32'd1);
         check_val("bp_req", 32'(imem_req), 32'd0);
         check_val("bp_instr", 32'(instr), 32'(e.word));
         check_val("bp_pc", 32'(pc), 32'(e.addr));
      end
      imem_ack    = 1'b0;
      instr_ready = 1'b1;
      pc_write    = pw;
      pc_target   = tgt;
      exp_addr    = pw ? tgt : e.addr + 16'd1;
      if (spacing) check_val("issue_spacing", 32'(cyc - last_issue), 32'd2);
      last_issue = cyc;
      @(negedge clk);
      pc_write    = 1'b0;
      pc_target   = 16'h0000;
      instr_ready = keep_ready;
      check_val("post_valid", 32'(instr_valid), 32'd0);
      check_val("post_req", 32'(imem_req), 32'd1);
      check_val("post_addr", 32'(imem_addr), 32'(exp_addr));
      $display("[TB] issued pc=%h instr=%h op=%h next=%h", e.addr, e.word, e.word[15:12], exp_addr);
   endtask

   task automatic check_reset_vals(input string tag);
      check_val({tag, "_req"}, 32'(imem_req), 32'd0);
      check_val({tag, "_addr"}, 32'(imem_addr), 32'(RST_PC));
      check_val({tag, "_instr"}, 32'(instr), 32'd0);
      check_val({tag, "_op"}, 32'(op), 32'd0);
      check_val({tag, "_pc"}, 32'(pc), 32'(RST_PC));
      check_val({tag, "_valid"}, 32'(instr_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset_n     = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = 16'h0000;
      instr_ready = 1'b0;
      pc_write    = 1'b0;
      pc_target   = 16'h0000;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");

      // Release; first request appears after exactly one edge.
      reset_n = 1'b1;
      @(negedge clk);
      check_val("first_req", 32'(imem_req), 32'd1);
      check_val("first_addr", 32'(imem_addr), 32'(RST_PC));
      fetch_issue(0, 16'h1234, 0, 1'b0, 1'b0, 16'h0, 1'b0);

      // Zero-wait stream with ready held high.
      keep_ready  = 1'b1;
      instr_ready = 1'b1;
      fetch_issue(0, 16'h2111, 0, 1'b0, 1'b0, 16'h0, 1'b1);
      fetch_issue(0, 16'h3222, 0, 1'b0, 1'b0, 16'h0, 1'b1);
      fetch_issue(0, 16'h4333, 0, 1'b0, 1'b0, 16'h0, 1'b1);
      keep_ready  = 1'b0;
      instr_ready = 1'b0;

      // Wait states, jal redirect, backpressure with ignored pc_write, wrap.
      fetch_issue(3, 16'h5444, 0, 1'b0, 1'b0, 16'h0, 1'b0);
      fetch_issue(0, 16'h6AAA, 0, 1'b0, 1'b1, 16'h0040, 1'b0);
      fetch_issue(0, 16'h7BBB, 5, 1'b1, 1'b0, 16'h0, 1'b0);
      fetch_issue(0, 16'h8CCC, 0, 1'b0, 1'b1, 16'hFFFF, 1'b0);
      fetch_issue(1, 16'h9DDD, 0, 1'b0, 1'b0, 16'h0, 1'b0);
      check_val("wrap_addr", 32'(imem_addr), 32'h0000);

      // Move to a non-reset address, then reset while the request is pending.
      fetch_issue(0, 16'hA111, 0, 1'b0, 1'b1, 16'h0123, 1'b0);
      #2 reset_n = 1'b0;
      #1 check_reset_vals("midrst");
      sb.delete();
      @(negedge clk);
      reset_n    = 1'b1;
      imem_ack   = 1'b1;
      imem_rdata = 16'hBAD0;
      @(negedge clk);
      imem_ack = 1'b0;
      check_val("refetch_req", 32'(imem_req), 32'd1);
      check_val("refetch_addr", 32'(imem_addr), 32'(RST_PC));
      check_val("stray_valid", 32'(instr_valid), 32'd0);
      check_val("stray_instr", 32'(instr), 32'd0);
      exp_addr = RST_PC;

      for (int k = 0; k < 4; k++) begin
         fetch_issue(int'($urandom_range(0, 2)), 16'($urandom), int'($urandom_range(0, 2)),
                     1'($urandom), 1'b0, 16'h0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
